// File: rtl/core_dma_initiator.sv
// Cluster-side DMA initiator: converts write commands plus a payload stream into
// registered write beats, read commands into registered read beats, and forwards
// read responses as a framed stream with a per-command last flag.
module core_dma_initiator #(
  parameter int DATA_WIDTH      = 64,
  parameter int STRB_WIDTH      = DATA_WIDTH/8,
  parameter int ADDR_WIDTH      = 26,
  parameter int LEN_WIDTH       = 12,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_wr_cmd_addr,
  input  logic                  i_wr_cmd_hdr,
  input  logic                  i_wr_cmd_valid,
  output logic                  o_wr_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_s_wr_data,
  input  logic [STRB_WIDTH-1:0] i_s_wr_strb,
  input  logic                  i_s_wr_last,
  input  logic                  i_s_wr_valid,
  output logic                  o_s_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_rd_cmd_beats,
  input  logic                  i_rd_cmd_valid,
  output logic                  o_rd_cmd_ready,
  output logic [DATA_WIDTH-1:0] o_m_rd_data,
  output logic                  o_m_rd_last,
  output logic                  o_m_rd_valid,
  input  logic                  i_m_rd_ready,
  output logic                  o_dma_cmd_wr_en,
  output logic [ADDR_WIDTH-1:0] o_dma_cmd_wr_addr,
  output logic                  o_dma_cmd_hdr_wr_en,
  output logic [ADDR_WIDTH-3:0] o_dma_cmd_hdr_wr_addr,
  output logic [DATA_WIDTH-1:0] o_dma_cmd_wr_data,
  output logic [STRB_WIDTH-1:0] o_dma_cmd_wr_strb,
  output logic                  o_dma_cmd_wr_last,
  input  logic                  i_dma_cmd_wr_ready,
  output logic                  o_dma_cmd_rd_en,
  output logic [ADDR_WIDTH-1:0] o_dma_cmd_rd_addr,
  output logic                  o_dma_cmd_rd_last,
  input  logic                  i_dma_cmd_rd_ready,
  input  logic                  i_dma_rd_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_dma_rd_resp_data,
  output logic                  o_dma_rd_resp_ready,
  output logic                  o_wr_busy,
  output logic                  o_rd_busy,
  output logic                  o_err_zero_len
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic {W_IDLE, W_DATA} wr_state_t;
  typedef enum logic {R_IDLE, R_ISSUE} rd_state_t;

  wr_state_t             r_wr_state;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic                  r_wr_hdr;

  rd_state_t             r_rd_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [LEN_WIDTH-1:0]  r_rd_rem;
  logic                  r_err;
  logic [CW-1:0]         r_outst;
  logic [LEN_WIDTH-1:0]  r_ret_cnt;
  logic [LEN_WIDTH-1:0]  r_fifo [0:3];
  logic [2:0]            r_wptr;
  logic [2:0]            r_rptr;

  logic                  w_s_fire;
  logic                  w_rd_cmd_fire;
  logic                  w_rd_hs;
  logic                  w_resp_hs;
  logic                  w_rd_load;
  logic [CW-1:0]         w_issue_cnt;
  logic [2:0]            w_fifo_cnt;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [LEN_WIDTH-1:0]  w_fifo_head;
  logic [LEN_WIDTH-1:0]  w_ret_cur;

  assign o_wr_cmd_ready = (r_wr_state == W_IDLE);
  assign o_s_wr_ready   = (r_wr_state == W_DATA) && (!o_dma_cmd_wr_en || i_dma_cmd_wr_ready);
  assign w_s_fire       = i_s_wr_valid && o_s_wr_ready;
  assign o_wr_busy      = (r_wr_state == W_DATA) || o_dma_cmd_wr_en;

  assign w_fifo_cnt     = r_wptr - r_rptr;
  assign w_fifo_full    = w_fifo_cnt[2];
  assign w_fifo_empty   = (r_wptr == r_rptr);
  assign w_fifo_head    = r_fifo[r_rptr[1:0]];

  assign o_rd_cmd_ready = (r_rd_state == R_IDLE) && !w_fifo_full;
  assign w_rd_cmd_fire  = i_rd_cmd_valid && o_rd_cmd_ready;
  assign w_rd_hs        = o_dma_cmd_rd_en && i_dma_cmd_rd_ready;
  // The beat leaving the register this cycle is counted too, so a newly loaded
  // beat can never push the outstanding count past the limit when it is accepted.
  assign w_issue_cnt    = r_outst + CW'(w_rd_hs);
  assign w_rd_load      = (r_rd_state == R_ISSUE) && (!o_dma_cmd_rd_en || i_dma_cmd_rd_ready) &&
                          (w_issue_cnt < CW'(MAX_OUTSTANDING));

  // Responses with nothing outstanding are swallowed rather than forwarded.
  assign o_dma_rd_resp_ready = (r_outst == '0) || i_m_rd_ready;
  assign o_m_rd_valid        = i_dma_rd_resp_valid && (r_outst != '0);
  assign o_m_rd_data         = i_dma_rd_resp_data;
  assign w_resp_hs           = o_m_rd_valid && i_m_rd_ready;
  // A zero return counter means the head command has not been started yet.
  assign w_ret_cur           = (r_ret_cnt != '0) ? r_ret_cnt : w_fifo_head;
  assign o_m_rd_last         = !w_fifo_empty && (w_ret_cur == LEN_WIDTH'(1));

  assign o_rd_busy      = (r_rd_state == R_ISSUE) || (r_outst != '0) || !w_fifo_empty;
  assign o_err_zero_len = r_err;

  // Write FSM and registered write beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state            <= W_IDLE;
      r_wr_addr             <= '0;
      r_wr_hdr              <= 1'b0;
      o_dma_cmd_wr_en       <= 1'b0;
      o_dma_cmd_wr_addr     <= '0;
      o_dma_cmd_hdr_wr_en   <= 1'b0;
      o_dma_cmd_hdr_wr_addr <= '0;
      o_dma_cmd_wr_data     <= '0;
      o_dma_cmd_wr_strb     <= '0;
      o_dma_cmd_wr_last     <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: if (i_wr_cmd_valid) begin
          r_wr_addr  <= i_wr_cmd_addr & ADDR_MASK;
          r_wr_hdr   <= i_wr_cmd_hdr;
          r_wr_state <= W_DATA;
        end
        W_DATA: if (w_s_fire) begin
          r_wr_addr <= r_wr_addr + ADDR_STEP;
          if (i_s_wr_last) r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
      if (w_s_fire) begin
        o_dma_cmd_wr_en       <= 1'b1;
        o_dma_cmd_hdr_wr_en   <= r_wr_hdr;
        o_dma_cmd_wr_addr     <= r_wr_hdr ? '0 : r_wr_addr;
        o_dma_cmd_hdr_wr_addr <= r_wr_hdr ? r_wr_addr[ADDR_WIDTH-3:0] : '0;
        o_dma_cmd_wr_data     <= i_s_wr_data;
        o_dma_cmd_wr_strb     <= i_s_wr_strb;
        o_dma_cmd_wr_last     <= i_s_wr_last;
      end else if (i_dma_cmd_wr_ready) begin
        o_dma_cmd_wr_en     <= 1'b0;
        o_dma_cmd_hdr_wr_en <= 1'b0;
      end
    end
  end

  // Read issue FSM, length FIFO, outstanding and return counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state        <= R_IDLE;
      r_rd_addr         <= '0;
      r_rd_rem          <= '0;
      r_err             <= 1'b0;
      r_outst           <= '0;
      r_ret_cnt         <= '0;
      r_wptr            <= '0;
      r_rptr            <= '0;
      o_dma_cmd_rd_en   <= 1'b0;
      o_dma_cmd_rd_addr <= '0;
      o_dma_cmd_rd_last <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r_fifo[i] <= '0;
    end else begin
      r_err <= w_rd_cmd_fire && (i_rd_cmd_beats == '0);
      case (r_rd_state)
        R_IDLE: if (w_rd_cmd_fire && (i_rd_cmd_beats != '0)) begin
          r_rd_addr             <= i_rd_cmd_addr & ADDR_MASK;
          r_rd_rem              <= i_rd_cmd_beats;
          r_fifo[r_wptr[1:0]]   <= i_rd_cmd_beats;
          r_wptr                <= r_wptr + 3'd1;
          r_rd_state            <= R_ISSUE;
        end
        R_ISSUE: if (w_rd_load) begin
          r_rd_addr <= r_rd_addr + ADDR_STEP;
          r_rd_rem  <= r_rd_rem - LEN_WIDTH'(1);
          if (r_rd_rem == LEN_WIDTH'(1)) r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
      if (w_rd_load) begin
        o_dma_cmd_rd_en   <= 1'b1;
        o_dma_cmd_rd_addr <= r_rd_addr;
        o_dma_cmd_rd_last <= (r_rd_rem == LEN_WIDTH'(1));
      end else if (i_dma_cmd_rd_ready) begin
        o_dma_cmd_rd_en <= 1'b0;
      end
      case ({w_rd_hs, w_resp_hs})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase
      if (w_resp_hs) begin
        if (w_ret_cur == LEN_WIDTH'(1)) begin
          r_ret_cnt <= '0;
          r_rptr    <= r_rptr + 3'd1;
        end else begin
          r_ret_cnt <= w_ret_cur - LEN_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_core_dma_initiator.sv
// Directed bench for core_dma_initiator: write bursts from a vector table, stall,
// wrapped reads, outstanding limit, zero-length rejection and mid-read reset.
module tb_core_dma_initiator;

  logic        clk;
  logic        rst_n;
  logic [25:0] i_wr_cmd_addr;
  logic        i_wr_cmd_hdr, i_wr_cmd_valid, o_wr_cmd_ready;
  logic [63:0] i_s_wr_data;
  logic [7:0]  i_s_wr_strb;
  logic        i_s_wr_last, i_s_wr_valid, o_s_wr_ready;
  logic [25:0] i_rd_cmd_addr;
  logic [11:0] i_rd_cmd_beats;
  logic        i_rd_cmd_valid, o_rd_cmd_ready;
  logic [63:0] o_m_rd_data;
  logic        o_m_rd_last, o_m_rd_valid, i_m_rd_ready;
  logic        o_dma_cmd_wr_en;
  logic [25:0] o_dma_cmd_wr_addr;
  logic        o_dma_cmd_hdr_wr_en;
  logic [23:0] o_dma_cmd_hdr_wr_addr;
  logic [63:0] o_dma_cmd_wr_data;
  logic [7:0]  o_dma_cmd_wr_strb;
  logic        o_dma_cmd_wr_last, i_dma_cmd_wr_ready;
  logic        o_dma_cmd_rd_en;
  logic [25:0] o_dma_cmd_rd_addr;
  logic        o_dma_cmd_rd_last, i_dma_cmd_rd_ready;
  logic        i_dma_rd_resp_valid;
  logic [63:0] i_dma_rd_resp_data;
  logic        o_dma_rd_resp_ready;
  logic        o_wr_busy, o_rd_busy, o_err_zero_len;

  core_dma_initiator #(.DATA_WIDTH(64), .ADDR_WIDTH(26), .LEN_WIDTH(12), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_cmd_addr(i_wr_cmd_addr), .i_wr_cmd_hdr(i_wr_cmd_hdr),
    .i_wr_cmd_valid(i_wr_cmd_valid), .o_wr_cmd_ready(o_wr_cmd_ready),
    .i_s_wr_data(i_s_wr_data), .i_s_wr_strb(i_s_wr_strb), .i_s_wr_last(i_s_wr_last),
    .i_s_wr_valid(i_s_wr_valid), .o_s_wr_ready(o_s_wr_ready),
    .i_rd_cmd_addr(i_rd_cmd_addr), .i_rd_cmd_beats(i_rd_cmd_beats),
    .i_rd_cmd_valid(i_rd_cmd_valid), .o_rd_cmd_ready(o_rd_cmd_ready),
    .o_m_rd_data(o_m_rd_data), .o_m_rd_last(o_m_rd_last),
    .o_m_rd_valid(o_m_rd_valid), .i_m_rd_ready(i_m_rd_ready),
    .o_dma_cmd_wr_en(o_dma_cmd_wr_en), .o_dma_cmd_wr_addr(o_dma_cmd_wr_addr),
    .o_dma_cmd_hdr_wr_en(o_dma_cmd_hdr_wr_en), .o_dma_cmd_hdr_wr_addr(o_dma_cmd_hdr_wr_addr),
    .o_dma_cmd_wr_data(o_dma_cmd_wr_data), .o_dma_cmd_wr_strb(o_dma_cmd_wr_strb),
    .o_dma_cmd_wr_last(o_dma_cmd_wr_last), .i_dma_cmd_wr_ready(i_dma_cmd_wr_ready),
    .o_dma_cmd_rd_en(o_dma_cmd_rd_en), .o_dma_cmd_rd_addr(o_dma_cmd_rd_addr),
    .o_dma_cmd_rd_last(o_dma_cmd_rd_last), .i_dma_cmd_rd_ready(i_dma_cmd_rd_ready),
    .i_dma_rd_resp_valid(i_dma_rd_resp_valid), .i_dma_rd_resp_data(i_dma_rd_resp_data),
    .o_dma_rd_resp_ready(o_dma_rd_resp_ready),
    .o_wr_busy(o_wr_busy), .o_rd_busy(o_rd_busy), .o_err_zero_len(o_err_zero_len)
  );

  typedef struct {
    logic        hdr;
    logic [25:0] cmd_addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [25:0] exp_addr;
    logic        exp_hdr;
    logic [23:0] exp_haddr;
  } wvec_t;

  typedef struct {
    logic [25:0] addr;
    logic        hdr;
    logic [23:0] haddr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    int          cyc;
  } wbeat_t;

  typedef struct { logic [25:0] addr; logic last; } rbeat_t;
  typedef struct { logic [63:0] data; logic last; } mbeat_t;
  typedef struct { int due; logic [25:0] addr; } pend_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int resp_delay = 2;
  int outst_m = 0;
  int outst_max = 0;
  wbeat_t wq[$];
  rbeat_t rq[$];
  mbeat_t mq[$];
  pend_t  pend[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rdat(input logic [25:0] a);
    return 64'hC0DE_0000_0000_0000 | {38'd0, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  // Monitors for issued beats, returned data and the bench-side core model
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      outst_m = 0;
    end else begin
      if (i_dma_rd_resp_valid && o_dma_rd_resp_ready && pend.size() > 0) begin
        void'(pend.pop_front());
        outst_m--;
      end
      if (o_dma_cmd_rd_en && i_dma_cmd_rd_ready) begin
        pend.push_back('{cyc + resp_delay, o_dma_cmd_rd_addr});
        rq.push_back('{o_dma_cmd_rd_addr, o_dma_cmd_rd_last});
        outst_m++;
      end
      if (outst_m > outst_max) outst_max = outst_m;
      if (o_dma_cmd_wr_en && i_dma_cmd_wr_ready)
        wq.push_back('{o_dma_cmd_wr_addr, o_dma_cmd_hdr_wr_en, o_dma_cmd_hdr_wr_addr,
                       o_dma_cmd_wr_data, o_dma_cmd_wr_strb, o_dma_cmd_wr_last, cyc});
      if (o_m_rd_valid && i_m_rd_ready)
        mq.push_back('{o_m_rd_data, o_m_rd_last});
    end
  end

  // Core read-response model: answers each issued beat resp_delay cycles later, in order
  initial begin
    i_dma_rd_resp_valid = 1'b0;
    i_dma_rd_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend.size() > 0 && cyc >= pend[0].due) begin
        i_dma_rd_resp_valid = 1'b1;
        i_dma_rd_resp_data  = rdat(pend[0].addr);
      end else begin
        i_dma_rd_resp_valid = 1'b0;
      end
    end
  end

  task automatic wr_cmd(input logic [25:0] a, input logic h);
    int n;
    i_wr_cmd_addr = a; i_wr_cmd_hdr = h; i_wr_cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_wr_cmd_ready && n < 100) begin n++; @(negedge clk); end
    if (!o_wr_cmd_ready) timeout("wr_cmd_ready");
    @(posedge clk); #1;
    i_wr_cmd_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n;
    i_s_wr_data = d; i_s_wr_strb = s; i_s_wr_last = l; i_s_wr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_s_wr_ready && n < 100) begin n++; @(negedge clk); end
    if (!o_s_wr_ready) timeout("s_wr_ready");
    @(posedge clk); #1;
    if (l) i_s_wr_valid = 1'b0;
  endtask

  task automatic rd_cmd(input logic [25:0] a, input logic [11:0] b);
    int n;
    i_rd_cmd_addr = a; i_rd_cmd_beats = b; i_rd_cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_rd_cmd_ready && n < 100) begin n++; @(negedge clk); end
    if (!o_rd_cmd_ready) timeout("rd_cmd_ready");
    @(posedge clk); #1;
    i_rd_cmd_valid = 1'b0;
  endtask

  task automatic wait_mq(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (mq.size() < n && k < budget) begin k++; @(negedge clk); end
    if (mq.size() < n) timeout(nm);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t wv[6];
    int b0, b1, m0, r0, stall_idx;
    logic [63:0] d3 [6];

    wv[0] = '{1'b0, 26'h000100, 64'h1111_0000_0000_0001, 8'hFF, 1'b0, 26'h000100, 1'b0, 24'h0};
    wv[1] = '{1'b0, 26'h000100, 64'h2222_0000_0000_0002, 8'h0F, 1'b0, 26'h000108, 1'b0, 24'h0};
    wv[2] = '{1'b0, 26'h000100, 64'h3333_0000_0000_0003, 8'hF0, 1'b0, 26'h000110, 1'b0, 24'h0};
    wv[3] = '{1'b0, 26'h000100, 64'h4444_0000_0000_0004, 8'h81, 1'b1, 26'h000118, 1'b0, 24'h0};
    wv[4] = '{1'b1, 26'h0000FD, 64'hAAAA_5555_0000_0005, 8'h3C, 1'b0, 26'h000000, 1'b1, 24'h0000F8};
    wv[5] = '{1'b1, 26'h0000FD, 64'hBBBB_6666_0000_0006, 8'hC3, 1'b1, 26'h000000, 1'b1, 24'h000100};

    rst_n = 1'b0;
    i_wr_cmd_addr = '0; i_wr_cmd_hdr = 1'b0; i_wr_cmd_valid = 1'b0;
    i_s_wr_data = '0; i_s_wr_strb = '0; i_s_wr_last = 1'b0; i_s_wr_valid = 1'b0;
    i_rd_cmd_addr = '0; i_rd_cmd_beats = '0; i_rd_cmd_valid = 1'b0;
    i_m_rd_ready = 1'b1; i_dma_cmd_wr_ready = 1'b1; i_dma_cmd_rd_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_wr_cmd_ready", o_wr_cmd_ready, 1);
    chk("rst_rd_cmd_ready", o_rd_cmd_ready, 1);
    chk("rst_s_wr_ready", o_s_wr_ready, 0);
    chk("rst_wr_en", o_dma_cmd_wr_en, 0);
    chk("rst_hdr_wr_en", o_dma_cmd_hdr_wr_en, 0);
    chk("rst_rd_en", o_dma_cmd_rd_en, 0);
    chk("rst_busy", {o_wr_busy, o_rd_busy, o_err_zero_len}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tests 1 and 2: table of write beats, ready always high
    b0 = wq.size();
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || wv[i-1].last) wr_cmd(wv[i].cmd_addr, wv[i].hdr);
      wr_beat(wv[i].data, wv[i].strb, wv[i].last);
      if (wv[i].last) begin
        @(negedge clk);
        chk($sformatf("wr%0d_busy_hold", i), o_wr_busy, 1);
        @(negedge clk);
        chk($sformatf("wr%0d_busy_drop", i), o_wr_busy, 0);
        @(posedge clk); #1;
      end
    end
    repeat (2) @(posedge clk); #1;
    chk("wr_tbl_count", wq.size() - b0, 6);
    if (wq.size() - b0 == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("wr%0d_addr", i), wq[b0+i].addr, wv[i].exp_addr);
        chk($sformatf("wr%0d_hdr", i), wq[b0+i].hdr, wv[i].exp_hdr);
        chk($sformatf("wr%0d_haddr", i), wq[b0+i].haddr, wv[i].exp_haddr);
        chk($sformatf("wr%0d_data", i), wq[b0+i].data, wv[i].data);
        chk($sformatf("wr%0d_strb", i), wq[b0+i].strb, wv[i].strb);
        chk($sformatf("wr%0d_last", i), wq[b0+i].last, wv[i].last);
      end
      for (int i = 1; i < 4; i++)
        chk($sformatf("wr%0d_back_to_back", i), wq[b0+i].cyc - wq[b0].cyc, i);
      chk("wr5_back_to_back", wq[b0+5].cyc - wq[b0+4].cyc, 1);
    end

    // Test 3: core stalls the write path for 5 cycles mid-burst
    for (int k = 0; k < 6; k++) d3[k] = 64'h3000_0000_0000_0000 + 64'(k * 17);
    b1 = wq.size();
    fork
      begin
        wr_cmd(26'h000200, 1'b0);
        for (int k = 0; k < 6; k++) wr_beat(d3[k], 8'hFF, k == 5);
      end
      begin
        int n;
        n = 0;
        while (wq.size() < b1 + 2 && n < 100) begin n++; @(negedge clk); end
        if (wq.size() < b1 + 2) timeout("stall_start");
        @(posedge clk); #1;
        i_dma_cmd_wr_ready = 1'b0;
        @(negedge clk);
        stall_idx = wq.size() - b1;
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          chk($sformatf("stall%0d_s_ready", s), o_s_wr_ready, 0);
          chk($sformatf("stall%0d_wr_en", s), o_dma_cmd_wr_en, 1);
          chk($sformatf("stall%0d_addr", s), o_dma_cmd_wr_addr, 26'h000200 + 26'(stall_idx * 8));
          chk($sformatf("stall%0d_data", s), o_dma_cmd_wr_data, d3[stall_idx]);
        end
        @(posedge clk); #1;
        i_dma_cmd_wr_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("stall_count", wq.size() - b1, 6);
    if (wq.size() - b1 == 6)
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("stall_beat%0d_addr", k), wq[b1+k].addr, 26'h000200 + 26'(k * 8));
        chk($sformatf("stall_beat%0d_data", k), wq[b1+k].data, d3[k]);
        chk($sformatf("stall_beat%0d_last", k), wq[b1+k].last, k == 5);
      end

    // Test 4: read that wraps the top of the address space
    begin
      rbeat_t rv[3];
      rv[0] = '{26'h3FFFFF8, 1'b0};
      rv[1] = '{26'h0000000, 1'b0};
      rv[2] = '{26'h0000008, 1'b1};
      resp_delay = 2;
      r0 = rq.size(); m0 = mq.size();
      rd_cmd(26'h3FFFFF8, 12'd3);
      wait_mq(m0 + 3, 200, "rd_wrap_resp");
      chk("rd_wrap_issue_count", rq.size() - r0, 3);
      if (rq.size() - r0 == 3 && mq.size() - m0 == 3)
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("rd_wrap%0d_addr", i), rq[r0+i].addr, rv[i].addr);
          chk($sformatf("rd_wrap%0d_cmd_last", i), rq[r0+i].last, rv[i].last);
          chk($sformatf("rd_wrap%0d_data", i), mq[m0+i].data, rdat(rv[i].addr));
          chk($sformatf("rd_wrap%0d_m_last", i), mq[m0+i].last, rv[i].last);
        end
      @(negedge clk);
      chk("rd_wrap_idle", o_rd_busy, 0);
      @(posedge clk); #1;
    end

    // Test 5: long read against a slow core
    resp_delay = 20;
    outst_max = 0;
    r0 = rq.size(); m0 = mq.size();
    rd_cmd(26'h0001000, 12'd40);
    wait_mq(m0 + 40, 3000, "rd_long_resp");
    chk("rd_long_outst_max", outst_max, 16);
    chk("rd_long_count", mq.size() - m0, 40);
    if (mq.size() - m0 == 40)
      for (int i = 0; i < 40; i++) begin
        chk($sformatf("rd_long%0d_data", i), mq[m0+i].data, rdat(26'h0001000 + 26'(i * 8)));
        chk($sformatf("rd_long%0d_last", i), mq[m0+i].last, i == 39);
      end
    repeat (2) @(posedge clk); #1;
    chk("rd_long_idle", o_rd_busy, 0);

    // Test 6a: zero-length read is rejected with a single-cycle error
    r0 = rq.size();
    rd_cmd(26'h0000400, 12'd0);
    @(negedge clk);
    chk("zl_err_pulse", o_err_zero_len, 1);
    chk("zl_no_rd_en", o_dma_cmd_rd_en, 0);
    @(negedge clk);
    chk("zl_err_clear", o_err_zero_len, 0);
    repeat (4) @(negedge clk);
    chk("zl_no_issue", rq.size() - r0, 0);
    chk("zl_not_busy", o_rd_busy, 0);
    @(posedge clk); #1;

    // Test 6b: reset in the middle of a read
    resp_delay = 5;
    rd_cmd(26'h0002000, 12'd30);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd_en", o_dma_cmd_rd_en, 0);
    chk("mid_rst_rd_busy", o_rd_busy, 0);
    chk("mid_rst_m_valid", o_m_rd_valid, 0);
    chk("mid_rst_rd_cmd_ready", o_rd_cmd_ready, 1);
    chk("mid_rst_wr_cmd_ready", o_wr_cmd_ready, 1);
    chk("mid_rst_wr_en", o_dma_cmd_wr_en, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resp_delay = 2;
    m0 = mq.size();
    rd_cmd(26'h0000040, 12'd2);
    wait_mq(m0 + 2, 200, "post_rst_resp");
    if (mq.size() - m0 >= 2) begin
      chk("post_rst0_data", mq[m0].data, rdat(26'h0000040));
      chk("post_rst0_last", mq[m0].last, 0);
      chk("post_rst1_data", mq[m0+1].data, rdat(26'h0000048));
      chk("post_rst1_last", mq[m0+1].last, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
